// File: rtl/rv32i_types.sv
// Shared RV32I fetch-side types.
//   op_jal / op_jalr : major opcodes of the two jump instructions
//   ras_cmd_t        : command issued to the return address stack
//   ras_log_t        : one in-flight log entry (command plus RAS state before it)
//   is_link()        : x1/x5 link-register test
//   is_jump()        : JAL, or JALR with funct3 000
//   classify()       : link-hint classification of a JAL/JALR word
package rv32i_types;

  localparam logic [6:0] op_jal  = 7'b1101111;
  localparam logic [6:0] op_jalr = 7'b1100111;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    PUSH     = 2'd1,
    POP      = 2'd2,
    POP_PUSH = 2'd3
  } ras_cmd_t;

  typedef struct packed {
    ras_cmd_t    kind;
    logic [31:0] saved_top;
    logic        saved_empty;
  } ras_log_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic logic is_jump(input logic [6:0] opcode, input logic [2:0] funct3);
    return (opcode == op_jal) || ((opcode == op_jalr) && (funct3 == 3'b000));
  endfunction

  // Only meaningful when is_jump() holds for the same fields.
  function automatic ras_cmd_t classify(input logic [6:0] opcode,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs1);
    ras_cmd_t cmd;
    cmd = NONE;
    if (opcode == op_jal) begin
      if (is_link(rd)) cmd = PUSH;
    end else begin
      if (is_link(rd) && !is_link(rs1))      cmd = PUSH;
      else if (is_link(rd) && is_link(rs1))  cmd = (rd == rs1) ? PUSH : POP_PUSH;
      else if (!is_link(rd) && is_link(rs1)) cmd = POP;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/ras_undo_log.sv
// Circular in-flight log of RAS commands.
//   clk, rst_n    : clock, asynchronous active-low reset
//   append        : write append_entry at the tail (newest)
//   append_entry  : entry to write
//   dequeue       : drop the oldest entry (commit)
//   undo          : drop the newest entry (repair)
//   count         : number of valid entries, 0..DEPTH
//   newest        : entry just below the tail (valid while count > 0)
// Storage is not reset; only the pointers and count are.
import rv32i_types::*;

module ras_undo_log #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          append,
  input  ras_log_t      append_entry,
  input  logic          dequeue,
  input  logic          undo,
  output logic [CW-1:0] count,
  output ras_log_t      newest
);

  ras_log_t mem [DEPTH];

  logic [AW-1:0] head_reg, head_next;
  logic [AW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;

  always_ff @(posedge clk) begin
    if (append) mem[tail_reg] <= append_entry;
  end

  // Pointers are AW bits wide, so +/-1 wraps modulo DEPTH for free.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (dequeue) begin
      head_next  = head_reg + AW'(1);
      count_next = count_next - CW'(1);
    end
    if (append) begin
      tail_next  = tail_next + AW'(1);
      count_next = count_next + CW'(1);
    end
    if (undo) begin
      tail_next  = tail_next - AW'(1);
      count_next = count_next - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  assign count  = count_reg;
  assign newest = mem[tail_reg - AW'(1)];

endmodule

// File: rtl/ras_spec_ctrl.sv
// Fetch-side return-address-stack controller.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   fetch_valid/pc/inst, ready     : fetch slot handshake
//   pred_valid, pred_target        : return prediction (target = RAS top)
//   ras_push/pop/pop_push, ras_din : RAS commands (at most one high), push data
//   ras_dout, ras_empty            : RAS top-of-stack and empty flag
//   commit_valid                   : oldest in-flight JAL/JALR retired
//   flush                          : squash all uncommitted JAL/JALR
// Each accepted JAL/JALR drives its RAS command combinationally and logs the
// RAS top it is about to disturb. On flush the log is unwound newest-first,
// one inverse command per cycle, with fetch held off.
import rv32i_types::*;

module ras_spec_ctrl #(
  parameter int INFLIGHT_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_inst,
  output logic        fetch_ready,
  output logic        pred_valid,
  output logic [31:0] pred_target,
  output logic        ras_push,
  output logic        ras_pop,
  output logic        ras_pop_push,
  output logic [31:0] ras_din,
  input  logic [31:0] ras_dout,
  input  logic        ras_empty,
  input  logic        commit_valid,
  input  logic        flush
);

  localparam int CW = $clog2(INFLIGHT_DEPTH) + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    REPAIR = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [CW-1:0] log_count;
  logic [CW-1:0] remaining;
  logic          log_append;
  logic          log_dequeue;
  logic          log_undo;
  ras_log_t      log_entry;
  ras_log_t      undo_entry;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic       fetch_jump;
  ras_cmd_t   fetch_cmd;
  logic       unused_imm;

  assign opcode     = fetch_inst[6:0];
  assign rd         = fetch_inst[11:7];
  assign funct3     = fetch_inst[14:12];
  assign rs1        = fetch_inst[19:15];
  assign unused_imm = ^fetch_inst[31:20];
  assign fetch_jump = is_jump(opcode, funct3);
  assign fetch_cmd  = classify(opcode, rd, rs1);

  assign pred_target = ras_dout;

  ras_undo_log #(
    .DEPTH (INFLIGHT_DEPTH)
  ) u_log (
    .clk          (clk),
    .rst_n        (rst_n),
    .append       (log_append),
    .append_entry (log_entry),
    .dequeue      (log_dequeue),
    .undo         (log_undo),
    .count        (log_count),
    .newest       (undo_entry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    fetch_ready  = 1'b0;
    pred_valid   = 1'b0;
    ras_push     = 1'b0;
    ras_pop      = 1'b0;
    ras_pop_push = 1'b0;
    ras_din      = '0;
    log_append   = 1'b0;
    log_dequeue  = 1'b0;
    log_undo     = 1'b0;
    log_entry    = '{kind: NONE, saved_top: ras_dout, saved_empty: ras_empty};
    remaining    = log_count;

    case (state_reg)
      IDLE: begin
        fetch_ready = !flush && (log_count < CW'(INFLIGHT_DEPTH));
        log_dequeue = commit_valid && (log_count != '0);
        if (log_dequeue) remaining = log_count - CW'(1);

        // NONE-class jumps still take an entry so commits stay aligned.
        if (fetch_valid && fetch_ready && fetch_jump) begin
          log_append     = 1'b1;
          log_entry.kind = fetch_cmd;
          ras_din        = fetch_pc + 32'd4;
          case (fetch_cmd)
            PUSH:     ras_push     = 1'b1;
            POP:      ras_pop      = 1'b1;
            POP_PUSH: ras_pop_push = 1'b1;
            default:  ;
          endcase
          pred_valid = ((fetch_cmd == POP) || (fetch_cmd == POP_PUSH)) && !ras_empty;
        end

        // Commit in the flush cycle is taken first; only what is left is undone.
        if (flush && (remaining != '0)) state_next = REPAIR;
      end

      REPAIR: begin
        log_undo = 1'b1;
        case (undo_entry.kind)
          PUSH: ras_pop = 1'b1;
          POP: begin
            if (!undo_entry.saved_empty) begin
              ras_push = 1'b1;
              ras_din  = undo_entry.saved_top;
            end
          end
          POP_PUSH: begin
            if (!undo_entry.saved_empty) begin
              ras_pop_push = 1'b1;
              ras_din      = undo_entry.saved_top;
            end else begin
              ras_pop = 1'b1;
            end
          end
          default: ;
        endcase
        if (log_count == CW'(1)) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // Commits cannot arrive while the log is being unwound.
  a_no_commit_in_repair: assert property (@(posedge clk) disable iff (!rst_n)
    !((state_reg == REPAIR) && commit_valid));

  a_one_cmd: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({ras_push, ras_pop, ras_pop_push}));

endmodule

// File: doc/ras_spec_ctrl.md
# ras_spec_ctrl

Fetch-side controller that drives the return address stack: it decodes each fetched instruction, classifies JAL/JALR per the RISC-V link-register hint rules, and issues push/pop/pop_push commands with the link address. Each command is logged in a small in-flight buffer. Commit retires log entries oldest-first. A pipeline flush replays inverse commands newest-first, one per cycle, and stalls fetch meanwhile. This is the controller ahead of the RAS instance in the fetch stage.

## Interface
- `INFLIGHT_DEPTH`, default 8: log entries; power of 2, ≥2.
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `fetch_valid`  in  1  fetch slot holds an instruction
- `fetch_pc`  in  32  PC of fetched instruction
- `fetch_inst`  in  32  fetched instruction word
- `fetch_ready`  out  1  slot accepted this cycle
- `pred_valid`  out  1  accepted pop/pop_push with RAS non-empty
- `pred_target`  out  32  predicted return target (= `ras_dout`)
- `ras_push` / `ras_pop` / `ras_pop_push`  out  1 each  RAS commands, at most one high
- `ras_din`  out  32  push data
- `ras_dout`  in  32  RAS top of stack
- `ras_empty`  in  1  RAS empty
- `commit_valid`  in  1  one JAL/JALR retired in program order
- `flush`  in  1  squash all uncommitted instructions

## Operation
- Link register: x1 or x5. JAL = opcode 1101111. JALR = opcode 1100111 with funct3 000.
- Classification:
  - JAL, rd link: push.
  - JALR, rd link, rs1 non-link: push.
  - JALR, rd and rs1 both link, rd==rs1: push.
  - JALR, rd and rs1 both link, rd≠rs1: pop_push.
  - JALR, rd non-link, rs1 link: pop.
  - Any other JAL/JALR: NONE.
- Accepted JAL/JALR (`fetch_valid && fetch_ready`):
  - Drive the command combinationally; `ras_din` = `fetch_pc + 4` (mod 2^32).
  - Append log entry {kind, saved_top=`ras_dout`, saved_empty=`ras_empty`}. NONE also allocates an entry, keeping commit aligned.
- Non-JAL/JALR instructions: no command, no entry.
- `commit_valid`: drop the oldest entry; no RAS action.
- Undo of the newest entry:
  - push → pop.
  - pop → push `saved_top` if `!saved_empty`, else nothing.
  - pop_push → pop_push `saved_top` if `!saved_empty`, else pop.
  - NONE → nothing.
- A push that overflowed the RAS (bottom lost) is not recoverable; repair restores top-of-stack only.
- States:
  - IDLE: normal operation.
  - REPAIR: entered on `flush` when log count>0. Undo one entry per cycle, newest first. Go to IDLE in the cycle the last entry is undone.
  - `flush` with an empty log stays in IDLE.

## Timing
- Reset (`rst_n`=0, async): state IDLE, log count 0, head/tail 0. Outputs: `fetch_ready`=1, all ras_* commands 0, `ras_din`=0, `pred_valid`=0.
- `fetch_ready` = IDLE && `!flush` && count<INFLIGHT_DEPTH.
- Zero-latency command path: the RAS updates at the accepting edge. `pred_target` is valid in the accept cycle.
- Same-cycle `commit_valid` and `flush`: commit dequeues the oldest entry first; the remaining entries are undone.
- Full log plus commit in the same cycle: `fetch_ready` stays 0 that cycle and rises the next.
- Flush with N entries logged: `fetch_ready` is low for N+1 cycles (flush cycle + N REPAIR cycles). Undo commands appear in REPAIR cycles 1..N.
- `flush` in REPAIR: ignored. `commit_valid` in REPAIR: protocol violation; covered by an assertion.
- Pointer wrap is modulo INFLIGHT_DEPTH. The count is $clog2(INFLIGHT_DEPTH)+1 bits.

## Structure
- Shared `rv32i_types` package:
  - Opcode constants `op_jal`, `op_jalr`.
  - `ras_cmd_t` enum {NONE, PUSH, POP, POP_PUSH}.
  - `ras_log_t` struct {kind, saved_top, saved_empty}.
- Sub-module `ras_undo_log`: circular buffer with tail append, head dequeue (commit) and tail pop (undo). The controller keeps only decode and the IDLE/REPAIR FSM.
- The RAS is instantiated by the parent, not inside this block.

## Test plan
- Reset: assert `rst_n`=0 mid-REPAIR → immediately `fetch_ready`=1, all commands 0, log count 0.
- Call: `fetch_pc`=0x1000, inst 0x008000EF (jal x1,8) → `ras_push`=1, `ras_din`=0x1004, count 1.
- Return: inst 0x00008067 (jalr x0,0(x1)), `ras_dout`=0x1004 → `ras_pop`=1, `pred_valid`=1, `pred_target`=0x1004.
- Coroutine and push-only forms:
  - 0x000082E7 (jalr x5,0(x1)) at 0x2000, `ras_dout`=0x1004 → `ras_pop_push`=1, `ras_din`=0x2004.
  - 0x000080E7 (jalr x1,0(x1)) → `ras_push`=1.
- Repair: call then return uncommitted, then `flush` → REPAIR cycle 1 `ras_push`=1 with `ras_din`=0x1004; cycle 2 `ras_pop`=1. `fetch_ready` low for 3 cycles, then high.
- Full/commit: 8 calls without commit → `fetch_ready`=0. `commit_valid`+`flush` in the same cycle → 7 undo pops, count 0.
